// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and the per-lane decode record
// used by the decode_stage_nw slice.
package decode_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;

   localparam int OPC_W = 7;
   localparam int REG_W = 5;
   localparam int F3_W  = 3;
   localparam int F7_W  = 7;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [F3_W-1:0]  func3;
      logic [F7_W-1:0]  func7;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             illegal;
   } lane_dec_t;

   function automatic logic is_supported(input logic [OPC_W-1:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-lane field split and illegal-opcode detection.
// DECODE_IMM_EN adds the sign-extended immediate output.
module decode_lane
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr,
   input  logic            lane_vld,
   output lane_dec_t       dec,
`ifdef DECODE_IMM_EN
   output logic [XLEN-1:0] imm,
`endif
   output logic [XLEN-1:0] instr_o
);

   // NOTE: every output gets a default before the conditional so no latch is inferred.
   always_comb begin
      dec     = '0;
      instr_o = '0;
      if (lane_vld) begin
         dec.opcode  = instr[OPC_LSB +: OPC_W];
         dec.rd      = instr[RD_LSB  +: REG_W];
         dec.func3   = instr[F3_LSB  +: F3_W];
         dec.rs1     = instr[RS1_LSB +: REG_W];
         dec.rs2     = instr[RS2_LSB +: REG_W];
         dec.func7   = instr[F7_LSB  +: F7_W];
         dec.illegal = !is_supported(instr[OPC_LSB +: OPC_W]);
         instr_o     = instr;
      end
   end

`ifdef DECODE_IMM_EN
   always_comb begin
      imm = '0;
      if (lane_vld) begin
         case (instr[OPC_LSB +: OPC_W])
            OP_I, OP_LOAD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OP_STORE:      imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            default:       imm = '0;
         endcase
      end
   end
`endif

endmodule

// File: rtl/decode_stage_nw.sv
// Registered N-wide decode stage: per-lane decode, output register plus 2-entry skid
// buffer behind a registered valid/ready handshake. DECODE_IMM_EN adds imm_o.
module decode_stage_nw
   import decode_pkg::*;
#(
   parameter int ISSUE_W = 2,
   parameter int XLEN    = 32,
   parameter int PC_W    = 7,
   parameter int CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ISSUE_W*XLEN-1:0] instr_i,
   input  logic [ISSUE_W*PC_W-1:0] pc_i,
   input  logic [ISSUE_W-1:0]      lane_vld_i,
   input  logic [CNT_W-1:0]        c_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ISSUE_W*7-1:0]    opcode_o,
   output logic [ISSUE_W*3-1:0]    func3_o,
   output logic [ISSUE_W*7-1:0]    func7_o,
   output logic [ISSUE_W*5-1:0]    rs1_o,
   output logic [ISSUE_W*5-1:0]    rs2_o,
   output logic [ISSUE_W*5-1:0]    rd_o,
   output logic [ISSUE_W*XLEN-1:0] instr_o,
   output logic [ISSUE_W*PC_W-1:0] pc_o,
   output logic [ISSUE_W-1:0]      lane_vld_o,
   output logic [ISSUE_W-1:0]      illegal_o,
`ifdef DECODE_IMM_EN
   output logic [ISSUE_W*XLEN-1:0] imm_o,
`endif
   output logic [CNT_W-1:0]        c_o
);

   typedef struct packed {
      logic [ISSUE_W*7-1:0]    opcode;
      logic [ISSUE_W*3-1:0]    func3;
      logic [ISSUE_W*7-1:0]    func7;
      logic [ISSUE_W*5-1:0]    rs1;
      logic [ISSUE_W*5-1:0]    rs2;
      logic [ISSUE_W*5-1:0]    rd;
      logic [ISSUE_W*XLEN-1:0] instr;
      logic [ISSUE_W*PC_W-1:0] pc;
      logic [ISSUE_W-1:0]      lane_vld;
      logic [ISSUE_W-1:0]      illegal;
`ifdef DECODE_IMM_EN
      logic [ISSUE_W*XLEN-1:0] imm;
`endif
      logic [CNT_W-1:0]        c;
   } bundle_t;

   lane_dec_t        dec       [ISSUE_W];
   logic [XLEN-1:0]  lane_inst [ISSUE_W];
`ifdef DECODE_IMM_EN
   logic [XLEN-1:0]  lane_imm  [ISSUE_W];
`endif

   for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
      decode_lane #(.XLEN(XLEN)) u_lane (
         .instr    (instr_i[k*XLEN +: XLEN]),
         .lane_vld (lane_vld_i[k]),
         .dec      (dec[k]),
`ifdef DECODE_IMM_EN
         .imm      (lane_imm[k]),
`endif
         .instr_o  (lane_inst[k])
      );
   end

   bundle_t in_bundle;

   always_comb begin
      in_bundle          = '0;
      in_bundle.pc       = pc_i;
      in_bundle.lane_vld = lane_vld_i;
      in_bundle.c        = c_i;
      for (int k = 0; k < ISSUE_W; k++) begin
         in_bundle.opcode[k*7 +: 7]       = dec[k].opcode;
         in_bundle.func3[k*3 +: 3]        = dec[k].func3;
         in_bundle.func7[k*7 +: 7]        = dec[k].func7;
         in_bundle.rs1[k*5 +: 5]          = dec[k].rs1;
         in_bundle.rs2[k*5 +: 5]          = dec[k].rs2;
         in_bundle.rd[k*5 +: 5]           = dec[k].rd;
         in_bundle.illegal[k]             = dec[k].illegal;
         in_bundle.instr[k*XLEN +: XLEN]  = lane_inst[k];
`ifdef DECODE_IMM_EN
         in_bundle.imm[k*XLEN +: XLEN]    = lane_imm[k];
`endif
      end
   end

   bundle_t    out_q;
   bundle_t    skid_q [2];
   logic [1:0] skid_cnt;
   logic [1:0] next_cnt;
   logic       accept;
   logic       out_load;

   always_comb begin
      accept   = in_valid && in_ready;
      out_load = !out_valid || out_ready;
      if (out_load)
         next_cnt = (skid_cnt == 2'd0) ? 2'd0 : skid_cnt - 2'd1 + {1'b0, accept};
      else
         next_cnt = skid_cnt + {1'b0, accept};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         skid_cnt  <= 2'd0;
         in_ready  <= 1'b0;
         out_q     <= '0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
         skid_cnt  <= 2'd0;
         in_ready  <= 1'b1;
      end else begin
         skid_cnt <= next_cnt;
         in_ready <= (next_cnt != 2'd2);
         if (out_load) begin
            if (skid_cnt != 2'd0) begin
               out_q     <= skid_q[0];
               out_valid <= 1'b1;
            end else if (accept) begin
               out_q     <= in_bundle;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   // NOTE: skid payload is not reset; skid_cnt alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (!flush_i) begin
         if (out_load && skid_cnt != 2'd0) begin
            if (skid_cnt == 2'd2)
               skid_q[0] <= skid_q[1];
            if (accept)
               skid_q[skid_cnt[1]] <= in_bundle;
         end else if (!out_load && accept) begin
            skid_q[skid_cnt[0]] <= in_bundle;
         end
      end
   end

   assign opcode_o   = out_q.opcode;
   assign func3_o    = out_q.func3;
   assign func7_o    = out_q.func7;
   assign rs1_o      = out_q.rs1;
   assign rs2_o      = out_q.rs2;
   assign rd_o       = out_q.rd;
   assign instr_o    = out_q.instr;
   assign pc_o       = out_q.pc;
   assign lane_vld_o = out_q.lane_vld;
   assign illegal_o  = out_q.illegal;
`ifdef DECODE_IMM_EN
   assign imm_o      = out_q.imm;
`endif
   assign c_o        = out_q.c;

endmodule

// File: tb/tb_decode_stage_nw.sv
// Directed bench for decode_stage_nw: table-driven decode vectors plus stall, flush
// and reset sequences; imm_o is checked when DECODE_IMM_EN is defined.
module tb_decode_stage_nw;

   localparam int ISSUE_W = 2;
   localparam int XLEN    = 32;
   localparam int PC_W    = 7;
   localparam int CNT_W   = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush_i;
   logic                    in_valid;
   logic                    in_ready;
   logic [ISSUE_W*XLEN-1:0] instr_i;
   logic [ISSUE_W*PC_W-1:0] pc_i;
   logic [ISSUE_W-1:0]      lane_vld_i;
   logic [CNT_W-1:0]        c_i;
   logic                    out_valid;
   logic                    out_ready;
   logic [ISSUE_W*7-1:0]    opcode_o;
   logic [ISSUE_W*3-1:0]    func3_o;
   logic [ISSUE_W*7-1:0]    func7_o;
   logic [ISSUE_W*5-1:0]    rs1_o;
   logic [ISSUE_W*5-1:0]    rs2_o;
   logic [ISSUE_W*5-1:0]    rd_o;
   logic [ISSUE_W*XLEN-1:0] instr_o;
   logic [ISSUE_W*PC_W-1:0] pc_o;
   logic [ISSUE_W-1:0]      lane_vld_o;
   logic [ISSUE_W-1:0]      illegal_o;
`ifdef DECODE_IMM_EN
   logic [ISSUE_W*XLEN-1:0] imm_o;
`endif
   logic [CNT_W-1:0]        c_o;

   decode_stage_nw #(
      .ISSUE_W(ISSUE_W), .XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr_i    (instr_i),
      .pc_i       (pc_i),
      .lane_vld_i (lane_vld_i),
      .c_i        (c_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .opcode_o   (opcode_o),
      .func3_o    (func3_o),
      .func7_o    (func7_o),
      .rs1_o      (rs1_o),
      .rs2_o      (rs2_o),
      .rd_o       (rd_o),
      .instr_o    (instr_o),
      .pc_o       (pc_o),
      .lane_vld_o (lane_vld_o),
      .illegal_o  (illegal_o),
`ifdef DECODE_IMM_EN
      .imm_o      (imm_o),
`endif
      .c_o        (c_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] ins, input logic [1:0] mask, input logic [31:0] c,
                        input logic vld);
      instr_i    = ins;
      lane_vld_i = mask;
      c_i        = c;
      pc_i       = {7'h2A, 7'h15};
      in_valid   = vld;
   endtask

   typedef struct {
      logic [63:0] instr;
      logic [1:0]  mask;
      logic [13:0] pc;
      logic [13:0] opc;
      logic [9:0]  rd;
      logic [5:0]  f3;
      logic [9:0]  rs1;
      logic [9:0]  rs2;
      logic [13:0] f7;
      logic [63:0] xinstr;
      logic [1:0]  ill;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{{32'h407302B3, 32'h002081B3}, 2'b11, {7'd5, 7'd4},
                  {7'h33, 7'h33}, {5'd5, 5'd3}, {3'd0, 3'd0}, {5'd6, 5'd1}, {5'd7, 5'd2},
                  {7'h20, 7'h00}, {32'h407302B3, 32'h002081B3}, 2'b00};
      vecs[1] = '{{32'hFFFFFFFF, 32'h00500093}, 2'b01, {7'd9, 7'd8},
                  {7'h00, 7'h13}, {5'd0, 5'd1}, {3'd0, 3'd0}, {5'd0, 5'd0}, {5'd0, 5'd5},
                  {7'h00, 7'h00}, {32'h00000000, 32'h00500093}, 2'b00};
      vecs[2] = '{{32'hFFFFFFFF, 32'h00500093}, 2'b11, {7'd11, 7'd10},
                  {7'h7F, 7'h13}, {5'd31, 5'd1}, {3'd7, 3'd0}, {5'd31, 5'd0}, {5'd31, 5'd5},
                  {7'h7F, 7'h00}, {32'hFFFFFFFF, 32'h00500093}, 2'b10};
      vecs[3] = '{{32'h00000003, 32'h0020A423}, 2'b11, {7'd13, 7'd12},
                  {7'h03, 7'h23}, {5'd0, 5'd8}, {3'd0, 3'd2}, {5'd0, 5'd1}, {5'd0, 5'd2},
                  {7'h00, 7'h00}, {32'h00000003, 32'h0020A423}, 2'b00};
      vecs[4] = '{{32'h0000007F, 32'h12345678}, 2'b10, {7'd15, 7'd14},
                  {7'h7F, 7'h00}, {5'd0, 5'd0}, {3'd0, 3'd0}, {5'd0, 5'd0}, {5'd0, 5'd0},
                  {7'h00, 7'h00}, {32'h0000007F, 32'h00000000}, 2'b10};
      vecs[5] = '{{32'hDEADBEEF, 32'hDEADBEEF}, 2'b00, {7'h7F, 7'h00},
                  {7'h00, 7'h00}, {5'd0, 5'd0}, {3'd0, 3'd0}, {5'd0, 5'd0}, {5'd0, 5'd0},
                  {7'h00, 7'h00}, 64'h0, 2'b00};

      rst = 1'b1; flush_i = 1'b0; out_ready = 1'b1;
      drive(64'h0, 2'b00, 32'd0, 1'b0);
      tick();
      check("reset out_valid", {63'h0, out_valid}, 64'h0);
      check("reset in_ready", {63'h0, in_ready}, 64'h0);
      check("reset opcode_o", {50'h0, opcode_o}, 64'h0);
      check("reset c_o", {32'h0, c_o}, 64'h0);
      rst = 1'b0;
      tick();
      check("in_ready after release", {63'h0, in_ready}, 64'h1);

      // Back-to-back decode vectors at full throughput.
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].instr, vecs[i].mask, 32'(i + 10), 1'b1);
         pc_i = vecs[i].pc;
         tick();
         check($sformatf("v%0d out_valid", i), {63'h0, out_valid}, 64'h1);
         check($sformatf("v%0d opcode", i), {50'h0, opcode_o}, {50'h0, vecs[i].opc});
         check($sformatf("v%0d rd", i), {54'h0, rd_o}, {54'h0, vecs[i].rd});
         check($sformatf("v%0d func3", i), {58'h0, func3_o}, {58'h0, vecs[i].f3});
         check($sformatf("v%0d rs1", i), {54'h0, rs1_o}, {54'h0, vecs[i].rs1});
         check($sformatf("v%0d rs2", i), {54'h0, rs2_o}, {54'h0, vecs[i].rs2});
         check($sformatf("v%0d func7", i), {50'h0, func7_o}, {50'h0, vecs[i].f7});
         check($sformatf("v%0d instr", i), instr_o, vecs[i].xinstr);
         check($sformatf("v%0d illegal", i), {62'h0, illegal_o}, {62'h0, vecs[i].ill});
         check($sformatf("v%0d pc", i), {50'h0, pc_o}, {50'h0, vecs[i].pc});
         check($sformatf("v%0d lane_vld", i), {62'h0, lane_vld_o}, {62'h0, vecs[i].mask});
         check($sformatf("v%0d c", i), {32'h0, c_o}, 64'(i + 10));
      end
      in_valid = 1'b0;
      tick();
      check("idle out_valid", {63'h0, out_valid}, 64'h0);

      // Stall: three bundles, one in output register and two in the skid.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive({32'h407302B3, 32'h002081B3}, 2'b11, 32'(100 + i), 1'b1);
         tick();
      end
      in_valid = 1'b0;
      check("stall in_ready low", {63'h0, in_ready}, 64'h0);
      check("stall head c", {32'h0, c_o}, 64'd100);
      tick();
      check("stall hold c", {32'h0, c_o}, 64'd100);
      out_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         tick();
         check($sformatf("drain%0d out_valid", i), {63'h0, out_valid}, 64'h1);
         check($sformatf("drain%0d c", i), {32'h0, c_o}, 64'(100 + i));
         check($sformatf("drain%0d in_ready", i), {63'h0, in_ready}, 64'h1);
      end
      tick();
      check("drained out_valid", {63'h0, out_valid}, 64'h0);

      // Flush with a full skid and a bundle offered in the flush cycle.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive({32'h407302B3, 32'h002081B3}, 2'b11, 32'(200 + i), 1'b1);
         tick();
      end
      drive({32'h407302B3, 32'h002081B3}, 2'b11, 32'd299, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      in_valid = 1'b0;
      check("flush out_valid", {63'h0, out_valid}, 64'h0);
      check("flush in_ready", {63'h0, in_ready}, 64'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post-flush%0d out_valid", i), {63'h0, out_valid}, 64'h0);
      end
      drive({32'h407302B3, 32'h002081B3}, 2'b11, 32'd300, 1'b1);
      tick();
      in_valid = 1'b0;
      check("post-flush new c", {32'h0, c_o}, 64'd300);
      check("post-flush new valid", {63'h0, out_valid}, 64'h1);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive({32'h407302B3, 32'h002081B3}, 2'b11, 32'(400 + i), 1'b1);
         tick();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async rst out_valid", {63'h0, out_valid}, 64'h0);
      check("async rst rd_o", {54'h0, rd_o}, 64'h0);
      check("async rst c_o", {32'h0, c_o}, 64'h0);
      check("async rst in_ready", {63'h0, in_ready}, 64'h0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post-rst%0d out_valid", i), {63'h0, out_valid}, 64'h0);
      end

`ifdef DECODE_IMM_EN
      drive({32'h0020A423, 32'h00500093}, 2'b11, 32'd500, 1'b1);
      tick();
      check("imm addi/sw", imm_o, {32'h00000008, 32'h00000005});
      drive({32'h002081B3, 32'hFFF00093}, 2'b11, 32'd501, 1'b1);
      tick();
      check("imm neg/rtype", imm_o, {32'h00000000, 32'hFFFFFFFF});
      drive({32'h0020A423, 32'hFFF00093}, 2'b00, 32'd502, 1'b1);
      tick();
      check("imm masked", imm_o, 64'h0);
      in_valid = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage_nw.md
Name: decode_stage_nw

Overview:
Registered N-wide instruction decode stage; successor to the combinational dual-issue decoder. Sits between fetch and issue/rename. Takes an ISSUE_W-wide bundle of instructions and PCs and splits each into opcode/func3/func7/rs1/rs2/rd fields. Adds per-lane validity, illegal-opcode flagging, a valid/ready handshake with a 2-entry skid buffer for full throughput, and synchronous flush.

Parameters:
ISSUE_W, 2, number of decode lanes (1..4)
XLEN, 32, instruction width
PC_W, 7, PC width per lane
CNT_W, 32, width of side-band counter c carried with the bundle

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush_i  in  1  discard all buffered and output bundles
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept a bundle this cycle
instr_i  in  ISSUE_W*XLEN  lane k at [k*XLEN +: XLEN]
pc_i  in  ISSUE_W*PC_W  per-lane PC
lane_vld_i  in  ISSUE_W  per-lane valid mask
c_i  in  CNT_W  side-band counter, passed through
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
opcode_o  out  ISSUE_W*7  per-lane opcode
func3_o  out  ISSUE_W*3  per-lane func3
func7_o  out  ISSUE_W*7  per-lane func7
rs1_o, rs2_o, rd_o  out  ISSUE_W*5 each  register fields
instr_o  out  ISSUE_W*XLEN  raw instruction passthrough
pc_o  out  ISSUE_W*PC_W  PC passthrough
lane_vld_o  out  ISSUE_W  lane mask passthrough
illegal_o  out  ISSUE_W  lane valid but opcode unsupported
c_o  out  CNT_W  counter passthrough

Behaviour:
- Reset (async): out_valid=0, skid empty, all data outputs 0, in_ready=0 while rst high, 1 the cycle after release.
- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- Latency 1 cycle input->output when output register free; throughput 1 bundle/cycle with continuous out_ready.
- in_ready is registered: in_ready = !skid_full. Output reg loads when !out_valid || out_ready: from skid entry if occupied, else from input. If output reg is stalled and input accepted, bundle goes to skid; a second bundle while stalled fills skid (2nd entry) -> in_ready drops next cycle.
- Order strictly FIFO; skid entries never overtaken.
- Field extraction per lane: opcode=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25].
- Lane with lane_vld=0: all decoded fields, instr_o, illegal_o zeroed; pc_o still passed.
- Supported opcodes: 0110011, 0010011, 0000011, 0100011. illegal_o[k]=lane_vld[k] && opcode not in set. Illegal lanes still decoded, not dropped.
- out_valid=0: data outputs hold last value (no requirement to zero).
- flush_i (sync, priority over all): next edge out_valid=0, skid emptied, in_ready=1; bundle offered in flush cycle is discarded.
- Simultaneous accept+transfer with full skid: skid head moves to output, new bundle written to skid tail; no loss.
- Reset mid-operation discards everything; no partial bundles.

Optional Feature:
DECODE_IMM_EN: adds output imm_o (ISSUE_W*XLEN) with sign-extended immediate per lane: I-type (0010011, 0000011) from [31:20], S-type (0100011) from {[31:25],[11:7]}, R-type 0; zero for invalid lanes; registered and buffered identically to other fields. Without macro: no imm_o port, no immediate logic.

Decomposition:
- Package decode_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE), field-position localparams, decoded-lane struct typedef.
- Sub-module decode_lane: combinational single-lane field extraction, illegal detection, optional immediate; instantiated ISSUE_W times by generate. Top holds handshake, skid buffer and output register.

Test Plan:
- Lane0=0x002081B3 (ADD x3,x1,x2), lane1=0x407302B3 (SUB x5,x6,x7), mask 11, out_ready=1 -> next cycle out_valid=1; lane0 rd=3 rs1=1 rs2=2 func7=0; lane1 rd=5 rs1=6 rs2=7 func7=0x20; illegal=00.
- out_ready=0, three back-to-back bundles -> first in output reg, two in skid, in_ready=0 after third; out_ready=1 -> bundles emerge in order, one per cycle, in_ready returns 1.
- Mask 01, lane1=0xFFFFFFFF -> lane1 fields and instr_o = 0, illegal_o=00; mask 11 same data -> illegal_o=10.
- Fill skid, assert flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and concurrently offered bundles never appear.
- Assert rst mid-stream with out_valid=1 -> out_valid and outputs 0 immediately; no stale bundle after release.
- With DECODE_IMM_EN: 0x00500093 (ADDI x1,x0,5) -> imm=5; 0x0020A423 (SW x2,8(x1)) -> imm=8; 0xFFF00093 -> imm=0xFFFFFFFF.
